// File: rtl/memory_port_arbiter_if.sv
// Request/ack bundle between the CPU and IOP requesters, the arbiter and the memory port.
// The slave modport is the arbiter's view; the master modport is the requester/memory-model view.
interface memory_port_arbiter_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;

  logic              iop_req;
  logic              iop_we;
  logic [ADDR_W-1:0] iop_addr;
  logic [DATA_W-1:0] iop_wdata;
  logic              iop_ack;
  logic [DATA_W-1:0] iop_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata,
    input  iop_req, iop_we, iop_addr, iop_wdata,
    output iop_ack, iop_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata,
    output iop_req, iop_we, iop_addr, iop_wdata,
    input  iop_ack, iop_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/memory_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory port between the CPU and the IOP.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  S_IDLE  | no access in flight; arbitrate cpu_req / iop_req
//  S_ISSUE | mem_en (and mem_we for writes) high for this single cycle
//  S_WAIT  | latency countdown; capture mem_rdata when cnt == 1
//  S_DONE  | owner's ack pulses for one cycle
module memory_port_arbiter #(
  parameter int ADDR_W      = 17,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  memory_port_arbiter_if.slave   bus,
  output logic                   busy,
  output logic                   owner
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam logic [3:0] LAT = 4'(MEM_LATENCY);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              last_grant_q;
  logic              we_q;
  logic              grant_cpu, grant_iop, grant;
  logic              capture;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    grant_cpu = 1'b0;
    grant_iop = 1'b0;
    capture   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.cpu_req && (!bus.iop_req || last_grant_q))
          grant_cpu = 1'b1;
        else if (bus.iop_req)
          grant_iop = 1'b1;
        if (grant_cpu || grant_iop)
          state_d = S_ISSUE;
      end
      S_ISSUE: begin
        cnt_d   = LAT;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          capture = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign grant     = grant_cpu | grant_iop;
  assign sel_we    = grant_iop ? bus.iop_we    : bus.cpu_we;
  assign sel_addr  = grant_iop ? bus.iop_addr  : bus.cpu_addr;
  assign sel_wdata = grant_iop ? bus.iop_wdata : bus.cpu_wdata;

  // Last-grant resets to IOP so the CPU wins the first tie.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.cpu_ack   <= 1'b0;
      bus.iop_ack   <= 1'b0;
      bus.cpu_rdata <= '0;
      bus.iop_rdata <= '0;
      busy          <= 1'b0;
      owner         <= 1'b0;
      last_grant_q  <= 1'b1;
      we_q          <= 1'b0;
    end else begin
      bus.mem_en  <= grant;
      bus.mem_we  <= grant & sel_we;
      bus.cpu_ack <= capture & ~owner;
      bus.iop_ack <= capture & owner;
      busy        <= (state_d != S_IDLE);
      if (grant) begin
        bus.mem_addr  <= sel_addr;
        bus.mem_wdata <= sel_wdata;
        we_q          <= sel_we;
        owner         <= grant_iop;
        last_grant_q  <= grant_iop;
      end
      if (capture && !we_q) begin
        if (owner) bus.iop_rdata <= bus.mem_rdata;
        else       bus.cpu_rdata <= bus.mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed bench for memory_port_arbiter: latency-2 main instance plus latency-1 and latency-15 builds.
module tb_memory_port_arbiter;

  logic        clock;
  logic        reset;
  logic        busy2, owner2, busy1, owner1, busy15, owner15;
  logic        mem_force;
  logic [31:0] mem_val;
  int          n_run, n_fail;
  int          n_acks, n_en;

  memory_port_arbiter_if #(.ADDR_W(17), .DATA_W(32)) b2 ();
  memory_port_arbiter_if #(.ADDR_W(17), .DATA_W(32)) b1 ();
  memory_port_arbiter_if #(.ADDR_W(17), .DATA_W(32)) b15 ();

  memory_port_arbiter #(.ADDR_W(17), .DATA_W(32), .MEM_LATENCY(2)) dut (
    .clock(clock), .reset(reset), .bus(b2.slave), .busy(busy2), .owner(owner2));
  memory_port_arbiter #(.ADDR_W(17), .DATA_W(32), .MEM_LATENCY(1)) dut_l1 (
    .clock(clock), .reset(reset), .bus(b1.slave), .busy(busy1), .owner(owner1));
  memory_port_arbiter #(.ADDR_W(17), .DATA_W(32), .MEM_LATENCY(15)) dut_l15 (
    .clock(clock), .reset(reset), .bus(b15.slave), .busy(busy15), .owner(owner15));

  // Memory models: data is a function of the held address unless a test forces a value.
  assign b2.mem_rdata  = mem_force ? mem_val : (32'hA000_0000 | 32'(b2.mem_addr));
  assign b1.mem_rdata  = 32'hB000_0000 | 32'(b1.mem_addr);
  assign b15.mem_rdata = 32'hC000_0000 | 32'(b15.mem_addr);

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_inputs();
    b2.cpu_req = 0; b2.cpu_we = 0; b2.cpu_addr = '0; b2.cpu_wdata = '0;
    b2.iop_req = 0; b2.iop_we = 0; b2.iop_addr = '0; b2.iop_wdata = '0;
    b1.cpu_req = 0; b1.cpu_we = 0; b1.cpu_addr = '0; b1.cpu_wdata = '0;
    b1.iop_req = 0; b1.iop_we = 0; b1.iop_addr = '0; b1.iop_wdata = '0;
    b15.cpu_req = 0; b15.cpu_we = 0; b15.cpu_addr = '0; b15.cpu_wdata = '0;
    b15.iop_req = 0; b15.iop_we = 0; b15.iop_addr = '0; b15.iop_wdata = '0;
  endtask

  initial begin
    n_run = 0; n_fail = 0;
    clr_inputs();
    mem_force = 1'b1;
    mem_val   = 32'h0;
    reset     = 1'b0;
    repeat (2) tick();

    // Reset state
    chk("rst_busy",      64'(busy2), 64'(0));
    chk("rst_owner",     64'(owner2), 64'(0));
    chk("rst_mem_en",    64'(b2.mem_en), 64'(0));
    chk("rst_mem_addr",  64'(b2.mem_addr), 64'(0));
    chk("rst_cpu_ack",   64'(b2.cpu_ack), 64'(0));
    chk("rst_cpu_rdata", 64'(b2.cpu_rdata), 64'(0));
    reset = 1'b1;
    tick();

    // Test 1: CPU read, latency 2
    b2.cpu_req = 1; b2.cpu_we = 0; b2.cpu_addr = 17'h00010;
    mem_val = 32'h0BAD_F00D;
    tick();
    chk("t1_mem_en",   64'(b2.mem_en), 64'(1));
    chk("t1_mem_we",   64'(b2.mem_we), 64'(0));
    chk("t1_mem_addr", 64'(b2.mem_addr), 64'h10);
    chk("t1_busy",     64'(busy2), 64'(1));
    chk("t1_owner",    64'(owner2), 64'(0));
    tick();
    chk("t1_mem_en_1cyc", 64'(b2.mem_en), 64'(0));
    tick();
    mem_val = 32'hDEAD_BEEF;
    chk("t1_no_early_ack", 64'(b2.cpu_ack), 64'(0));
    tick();
    mem_val = 32'h0BAD_F00D;
    chk("t1_cpu_ack",   64'(b2.cpu_ack), 64'(1));
    chk("t1_cpu_rdata", 64'(b2.cpu_rdata), 64'hDEAD_BEEF);
    chk("t1_iop_ack",   64'(b2.iop_ack), 64'(0));
    b2.cpu_req = 0;
    tick();
    chk("t1_ack_1cyc", 64'(b2.cpu_ack), 64'(0));
    chk("t1_idle",     64'(busy2), 64'(0));

    // Test 2: IOP write to top address
    b2.iop_req = 1; b2.iop_we = 1; b2.iop_addr = 17'h1FFFF; b2.iop_wdata = 32'h1234_5678;
    tick();
    chk("t2_mem_en",    64'(b2.mem_en), 64'(1));
    chk("t2_mem_we",    64'(b2.mem_we), 64'(1));
    chk("t2_mem_addr",  64'(b2.mem_addr), 64'h1FFFF);
    chk("t2_mem_wdata", 64'(b2.mem_wdata), 64'h1234_5678);
    chk("t2_owner",     64'(owner2), 64'(1));
    tick();
    chk("t2_mem_en_1cyc", 64'(b2.mem_en), 64'(0));
    chk("t2_mem_we_1cyc", 64'(b2.mem_we), 64'(0));
    tick();
    chk("t2_no_early_ack", 64'(b2.iop_ack), 64'(0));
    tick();
    chk("t2_iop_ack",     64'(b2.iop_ack), 64'(1));
    chk("t2_cpu_ack",     64'(b2.cpu_ack), 64'(0));
    chk("t2_iop_rdata",   64'(b2.iop_rdata), 64'(0));
    chk("t2_cpu_rdata",   64'(b2.cpu_rdata), 64'hDEAD_BEEF);
    b2.iop_req = 0; b2.iop_we = 0;
    tick();

    // Test 3: both requesters high from reset -> strict alternation, L+3 spacing
    reset = 1'b0;
    tick();
    reset = 1'b1;
    mem_force = 1'b0;
    b2.cpu_req = 1; b2.cpu_we = 0; b2.cpu_addr = 17'h00100;
    b2.iop_req = 1; b2.iop_we = 0; b2.iop_addr = 17'h00200;
    n_acks = 0; n_en = 0;
    for (int c = 1; c <= 36; c++) begin
      tick();
      if (b2.mem_en) begin
        chk("t3_grant_owner", 64'(owner2), 64'(n_en % 2));
        n_en++;
      end
      if (b2.cpu_ack || b2.iop_ack) begin
        chk("t3_ack_who", 64'(b2.iop_ack), 64'(n_acks % 2));
        chk("t3_ack_cyc", 64'(c), 64'(4 + 5 * n_acks));
        if (b2.iop_ack) chk("t3_iop_rdata", 64'(b2.iop_rdata), 64'hA000_0200);
        else            chk("t3_cpu_rdata", 64'(b2.cpu_rdata), 64'hA000_0100);
        n_acks++;
        if (n_acks == 6) begin
          b2.cpu_req = 0;
          b2.iop_req = 0;
        end
      end
    end
    chk("t3_ack_count",   64'(n_acks), 64'(6));
    chk("t3_grant_count", 64'(n_en), 64'(6));

    // Test 4: IOP request raised during a CPU access
    b2.cpu_req = 1; b2.cpu_we = 0; b2.cpu_addr = 17'h00300;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 2) begin
        b2.iop_req = 1; b2.iop_we = 1; b2.iop_addr = 17'h00400; b2.iop_wdata = 32'hCAFE_0004;
      end
      chk("t4_cpu_ack", 64'(b2.cpu_ack), 64'(c == 4));
      chk("t4_iop_ack", 64'(b2.iop_ack), 64'(c == 9));
      chk("t4_mem_en",  64'(b2.mem_en), 64'(c == 1 || c == 6));
      if (c == 4) begin
        chk("t4_cpu_rdata", 64'(b2.cpu_rdata), 64'hA000_0300);
        b2.cpu_req = 0;
      end
      if (c == 6) begin
        chk("t4_iop_owner", 64'(owner2), 64'(1));
        chk("t4_iop_we",    64'(b2.mem_we), 64'(1));
        chk("t4_iop_addr",  64'(b2.mem_addr), 64'h400);
      end
      if (c == 9) begin
        chk("t4_iop_rdata_hold", 64'(b2.iop_rdata), 64'hA000_0200);
        b2.iop_req = 0; b2.iop_we = 0;
      end
    end

    // Test 5: reset asserted during WAIT
    b2.cpu_req = 1; b2.cpu_we = 0; b2.cpu_addr = 17'h00500;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("t5_busy",      64'(busy2), 64'(0));
    chk("t5_mem_addr",  64'(b2.mem_addr), 64'(0));
    chk("t5_cpu_rdata", 64'(b2.cpu_rdata), 64'(0));
    chk("t5_mem_en",    64'(b2.mem_en), 64'(0));
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t5_no_ack", 64'(b2.cpu_ack), 64'(0));
    end
    reset = 1'b1;
    tick();
    chk("t5_re_mem_en",   64'(b2.mem_en), 64'(1));
    chk("t5_re_mem_addr", 64'(b2.mem_addr), 64'h500);
    tick();
    tick();
    chk("t5_re_no_early", 64'(b2.cpu_ack), 64'(0));
    tick();
    chk("t5_re_ack",   64'(b2.cpu_ack), 64'(1));
    chk("t5_re_rdata", 64'(b2.cpu_rdata), 64'hA000_0500);
    b2.cpu_req = 0;
    tick();

    // Test 6: latency 1 and 15 builds; req dropped during WAIT still acks
    b1.cpu_req = 1;  b1.cpu_we = 0;  b1.cpu_addr = 17'h00011;
    b15.cpu_req = 1; b15.cpu_we = 0; b15.cpu_addr = 17'h00015;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 2) b1.cpu_req = 0;
      if (c == 5) b15.cpu_req = 0;
      chk("t6_l1_ack",  64'(b1.cpu_ack), 64'(c == 3));
      chk("t6_l15_ack", 64'(b15.cpu_ack), 64'(c == 17));
      if (c == 3)  chk("t6_l1_rdata",  64'(b1.cpu_rdata), 64'hB000_0011);
      if (c == 17) chk("t6_l15_rdata", 64'(b15.cpu_rdata), 64'hC000_0015);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
